mem_access_initiator: RTL
=========================

MEM_ACCESS_INITIATOR -- requirements
Module: mem_access_initiator

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 1024: the maximum number of cycles spent in ISSUE plus WAIT_READ before an error response (used only with the macro).
REQ-002 SHALL provide ports, clock and reset first: clk in 1 (single clock); rst_n in 1 (asynchronous, active-low reset).
REQ-003 SHALL provide CPU-side ports: req_valid in 1; req_ready out 1; req_write in 1; req_addr in 32; req_wdata in 32 (right-aligned data); req_size in 2 (00 byte, 01 half, 10 word, 11 reserved); req_signed in 1 (sign-extend loads).
REQ-004 SHALL provide response ports: resp_valid out 1; resp_rdata out 32; resp_error out 1.
REQ-005 SHALL provide memory-side ports: cmd_start out 1; cmd_write out 1; cmd_ready in 1; addr out 32; rdata in 32; rdata_valid in 1; wdata out 32; wmask out 32 (bit mask).

Function
REQ-006 SHALL implement an FSM with states IDLE, ISSUE, WAIT_READ and RESP, and all outputs SHALL be registered.
REQ-007 SHALL drive req_ready=1 only in IDLE, and a request SHALL be accepted on req_valid && req_ready, latching all req_* fields.
REQ-008 SHALL treat as misaligned any half access with addr[0]=1, any word access with addr[1:0]!=0, and any req_size=11; such a request SHALL go to RESP with resp_error=1 and resp_rdata=0, with no memory command.
REQ-009 SHALL go from IDLE to ISSUE on an aligned accepted request, in the cycle after acceptance.
REQ-010 SHALL, in ISSUE, hold cmd_start=1, cmd_write=req_write, addr={req_addr[31:2],2'b00}, wdata=req_wdata shifted left by 8*addr[1:0], and wmask=0xFF per enabled byte lane (byte 0x000000FF<<8*off, half 0x0000FFFF<<8*off, word 0xFFFFFFFF).
REQ-011 SHALL complete the command transfer in a cycle with cmd_start && cmd_ready; cmd_start SHALL drop in the next cycle, and cmd_* SHALL stay stable while waiting.
REQ-012 SHALL, after a write transfer, go to RESP with resp_error=0 and resp_rdata=0.
REQ-013 SHALL, after a read transfer, go to WAIT_READ.
REQ-014 SHALL, on rdata_valid in WAIT_READ, take the lane rdata>>(8*off), zero-extend it (or sign-extend if req_signed) from 8/16 bits, and go to RESP.
REQ-015 SHALL ignore rdata_valid in any state other than WAIT_READ.
REQ-016 SHALL assert resp_valid for exactly one cycle in RESP (no backpressure) and then return to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-017 SHALL meet this latency for a write with cmd_ready high: accept at cycle N, cmd_start at N+1, resp_valid at N+2.
REQ-018 SHALL meet this latency for a read: resp_valid one cycle after the rdata_valid cycle.

Reset
REQ-019 SHALL, on rst_n=0 at any time including mid-transaction, go immediately to IDLE with req_ready=0 during reset and all other outputs 0 (resp_valid, resp_rdata, resp_error, cmd_start, cmd_write, addr, wdata, wmask).
REQ-020 SHALL drive req_ready=1 on the first clock edge after reset release.

Configuration
REQ-021 SHALL, with MEM_ACCESS_TIMEOUT_EN defined, count cycles in ISSUE+WAIT_READ; on reaching TIMEOUT_CYCLES it SHALL drop cmd_start and go to RESP with resp_error=1 and resp_rdata=0.
REQ-022 SHALL, without MEM_ACCESS_TIMEOUT_EN, contain no counter and wait indefinitely; resp_error then comes only from misalignment.

Structure
REQ-023 SHALL place the FSM state enum, req_size encodings (SIZE_B, SIZE_H, SIZE_W) and byte-mask constants in the shared package mem_access_pkg.
REQ-024 SHALL place lane alignment and extension logic in one combinational sub-module, mem_lane_align: write shift/mask and read extract/extend.

Verification
REQ-025 Byte store: addr 0x103, wdata 0x5A, cmd_ready=1 -> addr 0x100, wdata 0x5A000000, wmask 0xFF000000, resp_valid at N+2, error 0.
REQ-026 Signed half load: addr 0x202, rdata 0x8001xxxx -> resp_rdata 0xFFFF8001; unsigned -> 0x00008001.
REQ-027 Misaligned word: addr 0x301 -> no cmd_start, resp_valid next cycle, resp_error 1.
REQ-028 Backpressure: cmd_ready low 5 cycles -> cmd_start, addr and wmask stable throughout; single transfer; rdata_valid pulsed during ISSUE is ignored.
REQ-029 Reset asserted in WAIT_READ -> all outputs 0 asynchronously; after release, req_ready=1 and a subsequent word load of 0xDEADBEEF returns correctly.
REQ-030 With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=16, a read with no rdata_valid -> resp_error=1 after 16 cycles; without the macro -> no response.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access initiator.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (see mem_access_initiator).
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_READ,
        ST_RESP
    } state_e;

    // req_size encodings
    localparam logic [1:0] SIZE_B    = 2'b00;
    localparam logic [1:0] SIZE_H    = 2'b01;
    localparam logic [1:0] SIZE_W    = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Byte-lane masks before shifting to the addressed lane
    localparam logic [31:0] MASK_B = 32'h0000_00FF;
    localparam logic [31:0] MASK_H = 32'h0000_FFFF;
    localparam logic [31:0] MASK_W = 32'hFFFF_FFFF;

    // Half needs even address, word needs 4-byte alignment, reserved size always rejected
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = off[0];
            SIZE_W:  mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write data/mask placement and read lane extract/extend.
// Purely combinational; used by mem_access_initiator.
import mem_access_pkg::*;

module mem_lane_align (
    input  logic [1:0]  w_off,
    input  logic [1:0]  w_size,
    input  logic [31:0] w_data_in,
    output logic [31:0] w_data_out,
    output logic [31:0] w_mask,
    input  logic [1:0]  r_off,
    input  logic [1:0]  r_size,
    input  logic        r_signed,
    input  logic [31:0] r_data_in,
    output logic [31:0] r_data_out
);

    logic [31:0] lane;

    // Place right-aligned store data and its byte mask at the addressed lane
    always_comb begin
        w_data_out = w_data_in << {w_off, 3'b000};
        case (w_size)
            SIZE_B:  w_mask = MASK_B << {w_off, 3'b000};
            SIZE_H:  w_mask = MASK_H << {w_off, 3'b000};
            default: w_mask = MASK_W;
        endcase
    end

    // Pull the addressed lane down to bit 0 and zero/sign-extend it
    always_comb begin
        lane = r_data_in >> {r_off, 3'b000};
        case (r_size)
            SIZE_B:  r_data_out = {{24{r_signed & lane[7]}}, lane[7:0]};
            SIZE_H:  r_data_out = {{16{r_signed & lane[15]}}, lane[15:0]};
            default: r_data_out = lane;
        endcase
    end

endmodule

// File: rtl/mem_access_initiator.sv
// CPU load/store to simple memory command initiator with registered outputs.
// Define MEM_ACCESS_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog over ISSUE+WAIT_READ.
import mem_access_pkg::*;

module mem_access_initiator #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        cmd_start,
    output logic        cmd_write,
    input  logic        cmd_ready,
    output logic [31:0] addr,
    input  logic [31:0] rdata,
    input  logic        rdata_valid,
    output logic [31:0] wdata,
    output logic [31:0] wmask
);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;
    logic        cmd_start_q, cmd_start_d;
    logic        cmd_write_q, cmd_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wmask_q, wmask_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;

    logic [31:0] al_wdata;
    logic [31:0] al_wmask;
    logic [31:0] al_rdata;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_hit;
    assign tmo_hit = (tmo_q == TMO_LAST);
`endif

    // Write side steers live request fields; read side uses the latched request
    mem_lane_align u_align (
        .w_off      (req_addr[1:0]),
        .w_size     (req_size),
        .w_data_in  (req_wdata),
        .w_data_out (al_wdata),
        .w_mask     (al_wmask),
        .r_off      (off_q),
        .r_size     (size_q),
        .r_signed   (signed_q),
        .r_data_in  (rdata),
        .r_data_out (al_rdata)
    );

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        cmd_start_d  = cmd_start_q;
        cmd_write_d  = cmd_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        off_d        = off_q;
        size_d       = size_q;
        signed_d     = signed_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        tmo_d        = '0;
        if (state_q == ST_ISSUE || state_q == ST_WAIT_READ) begin
            tmo_d = tmo_q + 32'd1;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    off_d       = req_addr[1:0];
                    size_d      = req_size;
                    signed_d    = req_signed;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ST_ISSUE;
                        cmd_start_d = 1'b1;
                        cmd_write_d = req_write;
                        addr_d      = {req_addr[31:2], 2'b00};
                        wdata_d     = al_wdata;
                        wmask_d     = al_wmask;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_start_d = 1'b0;
                    if (cmd_write_q) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b0;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = ST_WAIT_READ;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (tmo_hit) begin
                    cmd_start_d  = 1'b0;
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_rdata_d = '0;
                end
`endif
            end
            ST_WAIT_READ: begin
                if (rdata_valid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = al_rdata;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_rdata_d = '0;
                end
`endif
            end
            default: begin
                // RESP: one-cycle response, ready again in the following cycle
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            cmd_start_q  <= 1'b0;
            cmd_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            cmd_start_q  <= cmd_start_d;
            cmd_write_q  <= cmd_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign cmd_start  = cmd_start_q;
    assign cmd_write  = cmd_write_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign wmask      = wmask_q;

endmodule
